// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access path: funct3 codes, FSM states,
// base byte enables and the legality/split helpers used by mem_access_unit.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [3:0] base_be(input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = BE_B;
      F3_H, F3_HU: be = BE_H;
      default:     be = BE_W;
    endcase
    return be;
  endfunction

  // True when the access touches bytes in the following word as well.
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    logic s;
    case (f3)
      F3_H, F3_HU: s = (off == 2'd3);
      F3_W:        s = (off != 2'd0);
      default:     s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Merges the two fetched words of a load, shifts the addressed bytes down to
// lane 0 and sign- or zero-extends according to funct3.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_w1,
  input  logic [31:0] i_w2,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [5:0]  w_sh;
  logic [31:0] w_raw;

  assign w_sh  = {1'b0, i_off, 3'b000};
  // ({w2,w1} >> 8*off)[31:0]; the w2 term vanishes when off is 0.
  assign w_raw = (i_w1 >> w_sh) | (i_w2 << (6'd32 - w_sh));

  always_comb begin
    o_data = w_raw;
    case (i_funct3)
      F3_B:    o_data = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_H:    o_data = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_BU:   o_data = {24'd0, w_raw[7:0]};
      F3_HU:   o_data = {16'd0, w_raw[15:0]};
      default: o_data = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store initiator for a word-organised data memory; splits
// word-crossing accesses. Define MISALIGN_TRAP_EN to trap them instead.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
`ifdef MISALIGN_TRAP_EN
  output logic              rsp_misalign,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  state_t              r_state, w_state_next;
  logic                r_we, r_err;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_addr;
  logic [XLEN-1:0]     r_wdata, r_w1, r_rdata;

  logic                w_accept, w_split;
  logic [1:0]          w_off;
  logic [5:0]          w_sh;
  logic [7:0]          w_be_wide;
  logic [ADDR_W-1:0]   w_base;
  logic [XLEN-1:0]     w_rot, w_ld_w1, w_ld_w2, w_ld_data, w_rdata_next;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_off     = r_addr[1:0];
  assign w_split   = is_split(r_funct3, w_off);
  assign w_be_wide = {4'b0000, base_be(r_funct3)} << w_off;
  assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_sh      = {1'b0, w_off, 3'b000};
  assign w_rot     = (r_wdata << w_sh) | (r_wdata >> (6'd32 - w_sh));

  // The word being read this cycle feeds the merge directly so the result
  // can be registered on the edge into RESP.
  assign w_ld_w1 = (r_state == ACC1) ? mem_rdata : r_w1;
  assign w_ld_w2 = (r_state == ACC2) ? mem_rdata : '0;

  load_align_ext u_load_align_ext (
    .i_w1     (w_ld_w1),
    .i_w2     (w_ld_w2),
    .i_off    (w_off),
    .i_funct3 (r_funct3),
    .o_data   (w_ld_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_rdata_next = '0;
    mem_addr     = '0;
    mem_be       = '0;
    mem_wdata    = '0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (!funct3_legal(req_funct3)) w_state_next = RESP;
`ifdef MISALIGN_TRAP_EN
          else if (is_split(req_funct3, req_addr[1:0])) w_state_next = RESP;
`endif
          else w_state_next = ACC1;
        end
      end
      ACC1: begin
        w_state_next = w_split ? ACC2 : RESP;
        if (!w_split && !r_we) w_rdata_next = w_ld_data;
        mem_addr  = w_base;
        mem_be    = w_be_wide[3:0];
        mem_wdata = w_rot;
        mem_rd_en = !r_we;
        mem_wr_en = r_we;
      end
      ACC2: begin
        w_state_next = RESP;
        if (!r_we) w_rdata_next = w_ld_data;
        mem_addr  = w_base + ADDR_W'(4);
        mem_be    = w_be_wide[7:4];
        mem_wdata = w_rot;
        mem_rd_en = !r_we;
        mem_wr_en = r_we;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = (r_state == RESP) && r_err;
  assign rsp_rdata = r_rdata;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  assign rsp_misalign = (r_state == RESP) && r_misalign;

  always_ff @(posedge clk) begin
    if (!rst_n) r_misalign <= 1'b0;
    else if (w_accept)
      r_misalign <= funct3_legal(req_funct3) && is_split(req_funct3, req_addr[1:0]);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_w1     <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_next;
      r_rdata <= w_rdata_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= !funct3_legal(req_funct3);
      end
      if (r_state == ACC1) r_w1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized check of mem_access_unit against a byte-level memory model;
// honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef MISALIGN_TRAP_EN
  logic        rsp_misalign;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] dmem [256];
  logic [7:0]  ref_mem [1024];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
`ifdef MISALIGN_TRAP_EN
    .rsp_misalign (rsp_misalign),
`endif
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) dmem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got);
    int size, off, lat, nstb, exp_lat, exp_nstb;
    logic legal, split, misal;
    logic [3:0]  exp_be [2];
    logic [31:0] exp_addr [2];
    logic [31:0] exp_wd, exp_rd, raw, ba;

    legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    off   = int'(addr[1:0]);
    split = legal && (off + size > 4);
    misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misal = split;
`endif
    // Byte j of the access lands in word (off+j)/4, lane (off+j)%4.
    exp_be[0] = '0;
    exp_be[1] = '0;
    for (int j = 0; j < size; j++) exp_be[(off + j) / 4][(off + j) % 4] = 1'b1;
    exp_addr[0] = {addr[31:2], 2'b00};
    exp_addr[1] = exp_addr[0] + 32'd4;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*((i - off + 4) % 4) +: 8];
    raw = '0;
    for (int j = 0; j < size; j++) begin
      ba = addr + 32'(j);
      raw[8*j +: 8] = ref_mem[ba[9:0]];
    end
    exp_rd = '0;
    if (legal && !we && !misal) begin
      case (f3)
        3'b000:  exp_rd = {{24{raw[7]}}, raw[7:0]};
        3'b001:  exp_rd = {{16{raw[15]}}, raw[15:0]};
        3'b100:  exp_rd = {24'd0, raw[7:0]};
        3'b101:  exp_rd = {16'd0, raw[15:0]};
        default: exp_rd = raw;
      endcase
    end
    exp_lat  = (!legal || misal) ? 1 : (split ? 3 : 2);
    exp_nstb = (!legal || misal) ? 0 : (split ? 2 : 1);

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    lat = -1; nstb = 0; got = '0;
    for (int cyc = 1; cyc <= 8 && lat < 0; cyc++) begin
      @(negedge clk);
      chk("busy_ready", 32'(req_ready), 32'd0);
      if (mem_rd_en || mem_wr_en) begin
        if (nstb < 2) begin
          chk("mem_addr", mem_addr, exp_addr[nstb]);
          chk("mem_be", 32'(mem_be), 32'(exp_be[nstb]));
          chk("mem_rd_en", 32'(mem_rd_en), 32'(!we));
          chk("mem_wr_en", 32'(mem_wr_en), 32'(we));
          if (we) chk("mem_wdata", mem_wdata, exp_wd);
        end
        nstb++;
      end
      if (rsp_valid) begin
        lat = cyc;
        got = rsp_rdata;
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(!legal));
`ifdef MISALIGN_TRAP_EN
        chk("rsp_misalign", 32'(rsp_misalign), 32'(misal));
`endif
        req_valid = 1'b0;
      end else begin
        chk("rdata_quiet", rsp_rdata, 32'd0);
        // Junk request while busy must be ignored.
        req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("strobes", 32'(nstb), 32'(exp_nstb));
    if (we && legal && !misal)
      for (int j = 0; j < size; j++) begin
        ba = addr + 32'(j);
        ref_mem[ba[9:0]] = wd[8*j +: 8];
      end
    @(negedge clk);
    chk("back_idle", {29'd0, req_ready, rsp_valid, mem_rd_en | mem_wr_en}, 32'b100);
    $display("txn we=%0d f3=%0d addr=%h wdata=%h rdata=%h lat=%0d", we, f3, addr, wd, got, lat);
  endtask

  task automatic rst_mid();
    logic [31:0] a, wd, ba;
    int off;
`ifdef MISALIGN_TRAP_EN
    a = 32'h60;
`else
    a = 32'h61;
`endif
    wd  = 32'h55667788;
    off = int'(a[1:0]);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_acc1", 32'(mem_wr_en), 32'd1);
    rst_n = 1'b0;
    // Only the first word's lanes are written before reset lands.
    for (int j = 0; j < 4 - off; j++) begin
      ba = a + 32'(j);
      ref_mem[ba[9:0]] = wd[8*j +: 8];
    end
    @(negedge clk);
    chk("rst_mid_quiet", {29'd0, rsp_valid, mem_rd_en | mem_wr_en, req_ready}, 32'b001);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_after", {29'd0, rsp_valid, mem_rd_en | mem_wr_en, req_ready}, 32'b001);
    end
    $display("txn reset-during-store addr=%h", a);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, w, a, d;
    logic [2:0]  f3;
    logic        we;
    int          nmis;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      dmem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ctl", 32'({rsp_valid, rsp_err, mem_rd_en, mem_wr_en, mem_be}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 3'b010, 32'h20, 32'hAABBCCDD, got);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, got);
    chk("tp_lw20", got, 32'hAABBCCDD);
    do_req(1'b1, 3'b000, 32'h23, 32'h00000080, got);
    do_req(1'b0, 3'b000, 32'h23, 32'h0, got);
    chk("tp_lb23", got, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h23, 32'h0, got);
    chk("tp_lbu23", got, 32'h00000080);
    do_req(1'b1, 3'b010, 32'h41, 32'h11223344, got);
    do_req(1'b0, 3'b010, 32'h41, 32'h0, got);
`ifndef MISALIGN_TRAP_EN
    chk("tp_lw41", got, 32'h11223344);
`endif
    do_req(1'b1, 3'b000, 32'h7, 32'h00000080, got);
    do_req(1'b1, 3'b000, 32'h8, 32'h0000007F, got);
    do_req(1'b0, 3'b001, 32'h7, 32'h0, got);
`ifndef MISALIGN_TRAP_EN
    chk("tp_lh7_pos", got, 32'h00007F80);
`endif
    do_req(1'b1, 3'b000, 32'h8, 32'h0000009F, got);
    do_req(1'b0, 3'b001, 32'h7, 32'h0, got);
`ifndef MISALIGN_TRAP_EN
    chk("tp_lh7_neg", got, 32'hFFFF9F80);
`endif
    do_req(1'b0, 3'b011, 32'h20, 32'h0, got);
    do_req(1'b0, 3'b010, 32'h2, 32'h0, got);
    do_req(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0, got);
    do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'hCAFE1234, got);

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ((f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) && $urandom_range(0, 3) != 0)
        f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      d = $urandom;
      do_req(we, f3, a, d, got);
    end

    rst_mid();

    nmis = 0;
    for (int i = 0; i < 256; i++) begin
      w = {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]};
      if (w !== dmem[i]) nmis++;
    end
    chk("mem_final", 32'(nmis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
